// File: rtl/npc_pkg.sv
// Shared types and default constants for the NPC sprite engine.
// Imported by the per-channel tracker and the top level.
package npc_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        DRAW = 1'b1
    } npc_state_t;

    localparam int         SPR_W_DEF     = 40;
    localparam int         SPR_H_DEF     = 78;
    localparam logic [7:0] START_KEY_DEF = 8'h15;

endpackage

// File: rtl/npc_channel.sv
// One NPC car channel: window compare, WAIT/DRAW state machine and
// the sprite line counter that supplies the ROM row address.
module npc_channel
    import npc_pkg::*;
#(
    parameter int SPR_W   = SPR_W_DEF,
    parameter int SPR_H   = SPR_H_DEF,
    parameter int COORD_W = 10,
    parameter int ROW_W   = $clog2(SPR_H),
    parameter int COL_W   = $clog2(SPR_W)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic [COORD_W-1:0] car_x,
    input  logic [COORD_W-1:0] car_y,
    input  logic               en,
    input  logic               hs_fall,
    output logic               in_draw,
    output logic [ROW_W-1:0]   row,
    output logic [COL_W-1:0]   col
);

    npc_state_t state;
    npc_state_t state_next;

    logic [COORD_W:0] x_ext;
    logic [COORD_W:0] y_ext;
    logic [COORD_W:0] x_lo;
    logic [COORD_W:0] y_lo;
    logic [COORD_W:0] x_hi;
    logic [COORD_W:0] y_hi;
    logic             x_in;
    logic             y_in;

    // One extra bit so a car near the right/bottom edge never wraps its bound.
    assign x_ext = {1'b0, DrawX};
    assign y_ext = {1'b0, DrawY};
    assign x_lo  = {1'b0, car_x};
    assign y_lo  = {1'b0, car_y};
    assign x_hi  = x_lo + (COORD_W + 1)'(SPR_W);
    assign y_hi  = y_lo + (COORD_W + 1)'(SPR_H);

    assign x_in = (x_ext >= x_lo) && (x_ext < x_hi);
    assign y_in = (y_ext >= y_lo) && (y_ext < y_hi);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Leaving on !x_in covers both the right edge and a scan wrap back to X=0.
    always_comb begin
        state_next = state;
        case (state)
            WAIT: begin
                if (en && x_in && y_in) begin
                    state_next = DRAW;
                end
            end
            DRAW: begin
                if (!en || !x_in || !y_in) begin
                    state_next = WAIT;
                end
            end
            default: state_next = WAIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            col <= '0;
        end else begin
            col <= COL_W'(x_ext - x_lo);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset || !en) begin
            row <= '0;
        end else if (hs_fall && y_in) begin
            if (row == ROW_W'(SPR_H - 1)) begin
                row <= '0;
            end else begin
                row <= row + 1'b1;
            end
        end
    end

    assign in_draw = (state == DRAW);

endmodule

// File: rtl/npc_sprite_engine.sv
// Multi-channel NPC car sprite engine: start latch, HS edge detect,
// lowest-index priority select across channels and sticky overlap flag.
module npc_sprite_engine
    import npc_pkg::*;
#(
    parameter int         NUM_NPC   = 4,
    parameter int         SPR_W     = SPR_W_DEF,
    parameter int         SPR_H     = SPR_H_DEF,
    parameter int         COORD_W   = 10,
    parameter logic [7:0] START_KEY = START_KEY_DEF,
    localparam int        ID_W      = (NUM_NPC > 1) ? $clog2(NUM_NPC) : 1,
    localparam int        ROW_W     = $clog2(SPR_H),
    localparam int        COL_W     = $clog2(SPR_W)
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [COORD_W-1:0]         DrawX,
    input  logic [COORD_W-1:0]         DrawY,
    input  logic                       VGA_HS,
    input  logic [NUM_NPC*COORD_W-1:0] CarX,
    input  logic [NUM_NPC*COORD_W-1:0] CarY,
    input  logic [NUM_NPC-1:0]         npc_en,
    input  logic [7:0]                 keycode,
    input  logic                       gamereset,
    output logic                       DrawNPC,
    output logic [ID_W-1:0]            npc_id,
    output logic [ROW_W-1:0]           spr_row,
    output logic [COL_W-1:0]           spr_col,
    output logic                       npc_overlap
);

    logic               started;
    logic               hs_q;
    logic               hs_fall;
    logic [NUM_NPC-1:0] draw_vec;
    logic [ROW_W-1:0]   row_arr [NUM_NPC];
    logic [COL_W-1:0]   col_arr [NUM_NPC];
    logic               any_draw;
    logic               multi_draw;
    logic [ID_W-1:0]    win_id;
    logic [ROW_W-1:0]   win_row;
    logic [COL_W-1:0]   win_col;

    // HS is only sampled in the Clk domain; a fall is a high-to-low step.
    assign hs_fall = hs_q & ~VGA_HS;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            started <= 1'b0;
            hs_q    <= 1'b1;
        end else begin
            hs_q <= VGA_HS;
            if (keycode == START_KEY) begin
                started <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_NPC; i++) begin : g_chan
        npc_channel #(
            .SPR_W  (SPR_W),
            .SPR_H  (SPR_H),
            .COORD_W(COORD_W),
            .ROW_W  (ROW_W),
            .COL_W  (COL_W)
        ) u_chan (
            .Clk    (Clk),
            .Reset  (Reset),
            .DrawX  (DrawX),
            .DrawY  (DrawY),
            .car_x  (CarX[i*COORD_W +: COORD_W]),
            .car_y  (CarY[i*COORD_W +: COORD_W]),
            .en     (npc_en[i]),
            .hs_fall(hs_fall),
            .in_draw(draw_vec[i]),
            .row    (row_arr[i]),
            .col    (col_arr[i])
        );
    end

    // Scanning downward leaves the lowest active index as the winner.
    always_comb begin
        any_draw   = |draw_vec;
        multi_draw = (draw_vec & (draw_vec - 1'b1)) != '0;
        win_id     = '0;
        win_row    = '0;
        win_col    = '0;
        for (int i = NUM_NPC - 1; i >= 0; i--) begin
            if (draw_vec[i]) begin
                win_id  = ID_W'(i);
                win_row = row_arr[i];
                win_col = col_arr[i];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            DrawNPC     <= 1'b0;
            npc_id      <= '0;
            spr_row     <= '0;
            spr_col     <= '0;
            npc_overlap <= 1'b0;
        end else begin
            DrawNPC <= any_draw & started & ~gamereset;
            npc_id  <= win_id;
            spr_row <= win_row;
            spr_col <= win_col;
            if (gamereset) begin
                npc_overlap <= 1'b0;
            end else if (multi_draw) begin
                npc_overlap <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_npc_sprite_engine.sv
// Directed bench for npc_sprite_engine: scans pixel windows and compares
// every registered output with a behavioural model two cycles behind.
module tb_npc_sprite_engine;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        VGA_HS;
    logic [39:0] CarX;
    logic [39:0] CarY;
    logic [3:0]  npc_en;
    logic [7:0]  keycode;
    logic        gamereset;
    logic        DrawNPC;
    logic [1:0]  npc_id;
    logic [6:0]  spr_row;
    logic [5:0]  spr_col;
    logic        npc_overlap;

    int checks = 0;
    int errors = 0;

    int mcx [4];
    int mcy [4];
    bit started_m;
    bit ov_m;
    bit chk_row;

    bit p_any;
    bit p_multi;
    int p_id;
    int p_row;
    int p_col;

    npc_sprite_engine dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .VGA_HS     (VGA_HS),
        .CarX       (CarX),
        .CarY       (CarY),
        .npc_en     (npc_en),
        .keycode    (keycode),
        .gamereset  (gamereset),
        .DrawNPC    (DrawNPC),
        .npc_id     (npc_id),
        .spr_row    (spr_row),
        .spr_col    (spr_col),
        .npc_overlap(npc_overlap)
    );

    always #5 Clk = ~Clk;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Lowest-index enabled car whose 40x78 window contains the pixel wins.
    function automatic void modelPixel(input int x, input int y, output bit any, output bit multi,
                                       output int id, output int row, output int col);
        any = 0; multi = 0; id = 0; row = 0; col = 0;
        for (int c = 3; c >= 0; c--) begin
            if (npc_en[c] && x >= mcx[c] && x < mcx[c] + 40 && y >= mcy[c] && y < mcy[c] + 78) begin
                if (any) multi = 1;
                any = 1;
                id  = c;
                row = y - mcy[c];
                col = x - mcx[c];
            end
        end
    endfunction

    task automatic setCar(input int c, input int x, input int y);
        mcx[c] = x;
        mcy[c] = y;
        CarX[c*10 +: 10] = x[9:0];
        CarY[c*10 +: 10] = y[9:0];
    endtask

    task automatic clearPipe();
        p_any = 0; p_multi = 0; p_id = 0; p_row = 0; p_col = 0;
    endtask

    // Present one pixel, clock it, then check the outputs for the previous pixel.
    task automatic applyStimulus(input int x, input int y, input bit hs);
        bit n_any, n_multi;
        int n_id, n_row, n_col;
        DrawX  = x[9:0];
        DrawY  = y[9:0];
        VGA_HS = hs;
        modelPixel(x, y, n_any, n_multi, n_id, n_row, n_col);
        @(posedge Clk);
        #1;
        ov_m = gamereset ? 1'b0 : (ov_m | p_multi);
        checkOutput("draw", 32'(DrawNPC), 32'(p_any & started_m & !gamereset));
        checkOutput("id", 32'(npc_id), p_id);
        checkOutput("col", 32'(spr_col), p_col);
        if (chk_row) checkOutput("row", 32'(spr_row), p_row);
        checkOutput("overlap", 32'(npc_overlap), 32'(ov_m));
        p_any = n_any; p_multi = n_multi; p_id = n_id; p_row = n_row; p_col = n_col;
    endtask

    task automatic scanLine(input int y, input int xlo, input int xhi);
        for (int x = xlo; x <= xhi; x++) applyStimulus(x, y, 1'b1);
        applyStimulus(700, y, 1'b1);
        applyStimulus(700, y, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(700, y, 1'b0);
        applyStimulus(700, y, 1'b1);
    endtask

    task automatic scanFrame(input int ylo, input int yhi, input int xlo, input int xhi);
        for (int y = ylo; y <= yhi; y++) scanLine(y, xlo, xhi);
    endtask

    task automatic resetDut();
        Reset  = 1'b0;
        DrawX  = 10'd700;
        DrawY  = 10'd700;
        VGA_HS = 1'b1;
        @(posedge Clk);
        #1;
        Reset     = 1'b1;
        started_m = 0;
        ov_m      = 0;
        chk_row   = 1;
        clearPipe();
    endtask

    task automatic pressStart();
        keycode = 8'h15;
        applyStimulus(700, 700, 1'b1);
        keycode   = 8'h00;
        started_m = 1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_draw"}, 32'(DrawNPC), 0);
        checkOutput({tag, "_id"}, 32'(npc_id), 0);
        checkOutput({tag, "_row"}, 32'(spr_row), 0);
        checkOutput({tag, "_col"}, 32'(spr_col), 0);
        checkOutput({tag, "_overlap"}, 32'(npc_overlap), 0);
    endtask

    initial begin
        Reset     = 1'b0;
        DrawX     = 10'd700;
        DrawY     = 10'd700;
        VGA_HS    = 1'b1;
        CarX      = '0;
        CarY      = '0;
        npc_en    = 4'b0000;
        keycode   = 8'h00;
        gamereset = 1'b0;
        for (int c = 0; c < 4; c++) setCar(c, 0, 0);
        setCar(0, 100, 50);
        setCar(1, 200, 100);
        setCar(2, 120, 60);
        setCar(3, 400, 300);
        repeat (2) @(posedge Clk);
        resetDut();
        checkAllZero("reset_state");

        $display("[TB] single car at (100,50) with start key");
        npc_en = 4'b0001;
        pressStart();
        scanFrame(45, 130, 80, 150);

        $display("[TB] single car without start key");
        resetDut();
        scanFrame(48, 60, 90, 150);

        $display("[TB] cars 0 and 2 overlapping");
        resetDut();
        npc_en = 4'b0101;
        pressStart();
        scanFrame(45, 100, 80, 170);
        gamereset = 1'b1;
        scanLine(101, 80, 170);
        gamereset = 1'b0;
        scanFrame(102, 140, 80, 170);
        checkOutput("overlap_sticky", 32'(npc_overlap), 1);
        gamereset = 1'b1;
        applyStimulus(700, 700, 1'b1);
        gamereset = 1'b0;
        checkOutput("overlap_cleared", 32'(npc_overlap), 0);

        $display("[TB] car clipped at right edge");
        resetDut();
        npc_en = 4'b0001;
        setCar(0, 620, 50);
        pressStart();
        scanFrame(48, 55, 0, 639);

        $display("[TB] channel 1 enable dropped at sprite line 30");
        resetDut();
        npc_en = 4'b0010;
        pressStart();
        scanFrame(98, 129, 190, 250);
        for (int x = 190; x < 210; x++) applyStimulus(x, 130, 1'b1);
        npc_en = 4'b0000;
        applyStimulus(210, 130, 1'b1);
        checkOutput("en_drop_state", 32'(dut.g_chan[1].u_chan.in_draw), 0);
        checkOutput("en_drop_row", 32'(dut.g_chan[1].u_chan.row), 0);
        scanLine(130, 211, 250);
        scanFrame(131, 180, 190, 250);
        npc_en = 4'b0010;
        scanFrame(95, 180, 190, 250);

        $display("[TB] reset pulse mid-sprite");
        resetDut();
        npc_en = 4'b0001;
        setCar(0, 100, 50);
        pressStart();
        scanFrame(48, 60, 90, 150);
        for (int x = 90; x < 120; x++) applyStimulus(x, 61, 1'b1);
        Reset = 1'b0;
        DrawX = 10'd120;
        DrawY = 10'd61;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        checkAllZero("mid_reset");
        started_m = 0;
        ov_m      = 0;
        chk_row   = 0;
        clearPipe();
        scanLine(61, 121, 150);
        scanFrame(62, 64, 90, 150);
        pressStart();
        scanLine(65, 90, 150);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
